// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - program-memory instruction sequencer feeding the 8-bit bus processor
module instr_sequencer #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 7
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          LoadEn,
    input  logic [AW-1:0] LoadAddr,
    input  logic [14:0]   LoadWord,
    input  logic          Start,
    input  logic          Abort,
    input  logic          Done,
    output logic          w,
    output logic [1:0]    F,
    output logic [1:0]    Rx,
    output logic [1:0]    Ry,
    output logic [7:0]    Data,
    output logic [AW-1:0] PC,
    output logic          Busy,
    output logic          Finished,
    output logic          Error,
    output logic [7:0]    Retired
);

    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t          state, state_n;
    logic [14:0]     mem [DEPTH];
    logic [14:0]     ir;
    logic [WW-1:0]   watchdog;
    logic            abort_q;
    logic            start_go;
    logic            last_instr;
    logic            timed_out;
    logic [AW-1:0]   pc_inc;

    assign start_go   = (state == IDLE) && Start && !LoadEn;
    assign last_instr = ir[14] || (PC == AW'(DEPTH - 1));
    assign timed_out  = (watchdog == WW'(TIMEOUT - 1));
    assign pc_inc     = PC + AW'(1);

    assign w    = (state == ISSUE);
    assign Busy = (state != IDLE);
    assign F    = ir[13:12];
    assign Rx   = ir[11:10];
    assign Ry   = ir[9:8];
    assign Data = ir[7:0];

    // Program memory has no reset; writes are accepted only while stopped.
    always_ff @(posedge Clock) begin
        if (state == IDLE && LoadEn)
            mem[LoadAddr] <= LoadWord;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start_go) state_n = ISSUE;
            ISSUE:   state_n = WAIT;
            WAIT: begin
                if (Done)
                    state_n = (last_instr || abort_q) ? IDLE : ISSUE;
                else if (timed_out)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            PC       <= '0;
            ir       <= '0;
            watchdog <= '0;
            abort_q  <= 1'b0;
            Finished <= 1'b0;
            Error    <= 1'b0;
            Retired  <= '0;
        end else begin
            Finished <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_go) begin
                        PC      <= '0;
                        ir      <= mem[0];
                        Retired <= '0;
                        Error   <= 1'b0;
                        abort_q <= 1'b0;
                    end
                end
                ISSUE: begin
                    watchdog <= '0;
                    if (Abort) abort_q <= 1'b1;
                end
                WAIT: begin
                    if (Abort) abort_q <= 1'b1;
                    if (Done) begin
                        Retired <= Retired + 8'd1;
                        // Abort suppresses Finished but never the retirement of the in-flight op.
                        if (last_instr || abort_q) begin
                            Finished <= last_instr && !abort_q;
                        end else begin
                            PC <= pc_inc;
                            ir <= mem[pc_inc];
                        end
                    end else begin
                        watchdog <= watchdog + WW'(1);
                        if (timed_out) Error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Instruction sequencer that sits directly upstream of the 8-bit bus processor. It holds a small program memory and issues one instruction at a time on the processor's `w`/`F`/`Rx`/`Ry`/`Data` inputs. It waits for the processor's `Done` before issuing the next instruction, so a stored program runs without external stimulus. It also provides a Done-timeout watchdog, an abort request and a retired-instruction counter.

## Interface
- `DEPTH`, 16: program memory words; must be a power of 2.
- `AW`, 4: address width, log2(DEPTH).
- `TIMEOUT`, 7: maximum WAIT cycles without `Done` before `Error` is raised.

- `Clock`  in  1  system clock, rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `LoadEn`  in  1  write `LoadWord` to `mem[LoadAddr]`; honoured only in IDLE.
- `LoadAddr`  in  AW  program write address.
- `LoadWord`  in  15  program word: [14]=Last, [13:12]=F, [11:10]=Rx, [9:8]=Ry, [7:0]=Imm.
- `Start`  in  1  begin execution at address 0; honoured only in IDLE and only when `LoadEn`=0.
- `Abort`  in  1  stop after the in-flight instruction completes.
- `Done`  in  1  processor Done, sampled on the clock edge.
- `w`  out  1  processor start strobe.
- `F`, `Rx`, `Ry`  out  2 each  processor instruction fields.
- `Data`  out  8  processor external data (Imm field).
- `PC`  out  AW  address of the current instruction.
- `Busy`  out  1  high in ISSUE or WAIT.
- `Finished`  out  1  one-cycle pulse when a program retires its Last instruction.
- `Error`  out  1  sticky watchdog flag; cleared by `Start` or `Reset`.
- `Retired`  out  8  count of instructions completed since `Start`; wraps modulo 256.

## Operation
- Memory: DEPTH x 15 bit array, not reset. Write is synchronous; read is asynchronous.
- IR: 15-bit register. `F`/`Rx`/`Ry`/`Data` are driven directly from IR and change only on edges that enter ISSUE.
- States:
  - IDLE: `w`=0.
    - `Start`=1 and `LoadEn`=0: PC<=0, IR<=mem[0], `Retired`<=0, `Error`<=0, abort latch<=0, go to ISSUE.
    - `LoadEn`=1: perform the write and stay in IDLE. A simultaneous `Start` is ignored.
  - ISSUE: `w`=1 for exactly this one cycle. Watchdog<=0. Go to WAIT.
  - WAIT: `w`=0. IR is held, so `Data` stays valid through the processor's Extern step. On `Done`=1:
    - `Retired`<=`Retired`+1.
    - If IR.Last=1, or PC=DEPTH-1, or the abort latch is set: go to IDLE. `Finished` pulses next cycle only when IR.Last=1 or PC=DEPTH-1 **and** the abort latch is clear.
    - Otherwise: PC<=PC+1, IR<=mem[PC+1], go to ISSUE.
    - If `Done`=0, watchdog<=watchdog+1. When the watchdog reaches TIMEOUT with `Done` still 0: `Error`<=1, go to IDLE, no `Finished`.
- `Abort` is latched when seen in ISSUE or WAIT. It never truncates an instruction already issued. In IDLE it is ignored.
- `LoadEn` while `Busy` is ignored; memory is unchanged.
- PC does not wrap. Address DEPTH-1 is implicitly the last instruction.

## Timing
- Reset (asynchronous): state=IDLE, PC=0, IR=0, `w`=0, `Busy`=0, `Finished`=0, `Error`=0, `Retired`=0, abort latch=0, watchdog=0. Outputs `F`/`Rx`/`Ry`/`Data` are 0.
- `Start` sampled at edge k → `w`=1 during cycle k+1.
- Processor `Done` arrives 1 cycle after `w` for load/move and 3 cycles after `w` for add/sub. This gives an issue-to-issue spacing of 2 and 4 cycles respectively.
- Reset asserted mid-program: all outputs go to reset values immediately. `w` drops asynchronously.
- `Done`=1 in ISSUE is ignored. The processor cannot assert it there.

## Test plan
- Load 4-word program {0,00,00,00,05}, {0,00,01,00,03}, {0,10,00,01,00}, {1,11,00,01,00}, then Start → `w` pulses at cycles 1, 3, 5, 9 after Start. Processor R0 goes 5 → 8 → 5. `Finished` pulses once. `Retired`=4. `Busy` is high for 12 cycles.
- Hold `Done`=0 after issue (processor stubbed) → `Error`=1 after 7 WAIT cycles. State returns to IDLE, `Finished` stays 0. A following Start clears `Error`.
- Abort pulse during WAIT of an add at PC=2 in a 4-word program → instruction retires (`Retired`=3), IDLE, no further `w`, no `Finished`.
- Program with no Last bit set in all 16 words → execution stops after PC=15. `Finished` pulses. `Retired`=16.
- `LoadEn` while `Busy`, writing to address 1 → after run completes, re-run shows the original word at address 1 executed. `LoadEn`+`Start` together in IDLE → word written, `Busy` stays 0.
- Reset asserted during WAIT of an add → `w`, `Busy`, `PC`, `Retired` go to 0 without waiting for a clock edge. Next Start restarts from address 0.
